// File: rtl/hash_pkg.sv
// Shared definitions for the message packer feeding the hasher.
// State encoding and datapath widths live here.
package hash_pkg;

    localparam int BYTE_W = 8;
    localparam int DATA_W = 64;
    localparam int LEN_W  = 4;

    // FILL must encode as zero: the register reset value is all-zeros.
    typedef enum logic [1:0] {
        FILL = 2'd0,
        DROP = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/hash_msg_packer_dffr.sv
// Width-parameterised register with synchronous active-high reset.
// Resets to all-zeros.
module dffr #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d each rising edge; rst clears to zero.
    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else     q <= d;
    end

endmodule

// File: rtl/hash_msg_packer.sv
// Byte-serial to 64-bit little-endian packer for the message hasher.
// Holds the packed word until the consumer acknowledges it.
module hash_msg_packer
    import hash_pkg::*;
#(
    parameter int MAX_BYTES = 8,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [LEN_W-1:0]  out_len,
    output logic              out_trunc,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  msg_count
);

    logic [1:0]        state_q;
    logic [1:0]        state_n;
    state_t            state;
    logic [LEN_W-1:0]  count_q;
    logic [LEN_W-1:0]  count_n;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_n;
    logic              trunc_q;
    logic              trunc_n;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_n;

    assign state = state_t'(state_q);

    dffr #(.W(2))      u_state (.clk(clk), .rst(rst), .d(state_n), .q(state_q));
    dffr #(.W(LEN_W))  u_count (.clk(clk), .rst(rst), .d(count_n), .q(count_q));
    dffr #(.W(DATA_W)) u_data  (.clk(clk), .rst(rst), .d(data_n),  .q(data_q));
    dffr #(.W(1))      u_trunc (.clk(clk), .rst(rst), .d(trunc_n), .q(trunc_q));
    dffr #(.W(CNT_W))  u_cnt   (.clk(clk), .rst(rst), .d(cnt_n),   .q(cnt_q));

    // Next-state, byte packing and handoff bookkeeping.
    always_comb begin
        state_n   = state_q;
        count_n   = count_q;
        data_n    = data_q;
        trunc_n   = trunc_q;
        cnt_n     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    for (int k = 0; k < DATA_W / BYTE_W; k++) begin
                        if (count_q == LEN_W'(k)) begin
                            data_n[k*BYTE_W +: BYTE_W] = in_byte;
                        end
                    end
                    count_n = count_q + 1'b1;
                    if (in_last) begin
                        state_n = HOLD;
                    end else if (count_n == LEN_W'(MAX_BYTES)) begin
                        state_n = DROP;
                    end
                end
            end
            DROP: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    trunc_n = 1'b1;
                    if (in_last) state_n = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_n = FILL;
                    count_n = '0;
                    data_n  = '0;
                    trunc_n = 1'b0;
                    cnt_n   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_n = FILL;
            end
        endcase
    end

    assign out_data  = data_q;
    assign out_len   = count_q;
    assign out_trunc = trunc_q;
    assign msg_count = cnt_q;

endmodule
